// File: rtl/press_pkg.sv
// Shared types and helpers for the press_classifier gesture decoder.
// Holds the per-channel FSM state encoding and the counter sizing function.
// Optional feature macro used by this slice: PRESS_CLASSIFIER_REPEAT_EN.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG           = 3'd4
  } press_state_t;

  // Counter width large enough to hold the largest of the three thresholds.
  function automatic int press_cnt_width(input int long_c, input int gap_c, input int rep_c);
    int m;
    m = long_c;
    if (gap_c > m) m = gap_c;
    if (rep_c > m) m = rep_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/press_channel.sv
// Purpose: one-button gesture FSM (short / long / double / auto-repeat) with a single saturating counter.
// Latency: every output is registered; events appear the cycle after the deciding btn sample.
// Backpressure: none; event pulses are fire-and-forget. Repeat logic exists only with PRESS_CLASSIFIER_REPEAT_EN.
module press_channel
  import press_pkg::*;
#(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic hold,
  output logic busy
);

  localparam int CW = press_cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);

  // The sample that enters PRESSED / SECOND_PRESSED / WAIT_SECOND is itself the
  // first high (or low) sample, and the counter is cleared on that entry, so the
  // N-th consecutive sample is seen when the counter holds N-2.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
`ifdef PRESS_CLASSIFIER_REPEAT_EN
  // In LONG the counter is cleared on the long_pulse sample, so the sample
  // REPEAT_CYCLES later is seen when the counter holds REPEAT_CYCLES-1.
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  press_state_t  state;
  press_state_t  nstate;
  logic [CW-1:0] cnt;
  logic          long_hit;
  logic          gap_hit;
  logic          rep_due;
  logic          ev_short;
  logic          ev_long;
  logic          ev_double;
  logic          ev_repeat;

  assign long_hit = (cnt >= LONG_LAST);
  assign gap_hit  = (cnt >= GAP_LAST);

  // Next-state and event decode; release is checked before any timeout so it always wins.
  always_comb begin
    nstate    = state;
    ev_short  = 1'b0;
    ev_long   = 1'b0;
    ev_double = 1'b0;
    ev_repeat = 1'b0;
    rep_due   = 1'b0;
    case (state)
      IDLE: begin
        if (btn) nstate = PRESSED;
      end
      PRESSED: begin
        if (!btn) begin
          nstate = WAIT_SECOND;
        end else if (long_hit) begin
          nstate  = LONG;
          ev_long = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (btn) begin
          nstate = SECOND_PRESSED;
        end else if (gap_hit) begin
          nstate   = IDLE;
          ev_short = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (!btn) begin
          nstate    = IDLE;
          ev_double = 1'b1;
        end else if (long_hit) begin
          // The first click is dropped: a long press overrides it.
          nstate  = LONG;
          ev_long = 1'b1;
        end
      end
      LONG: begin
        if (!btn) begin
          nstate = IDLE;
        end
`ifdef PRESS_CLASSIFIER_REPEAT_EN
        else if (cnt >= REP_LAST) begin
          rep_due   = 1'b1;
          ev_repeat = 1'b1;
        end
`endif
      end
      default: nstate = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Shared counter: clears on any state change or repeat, otherwise counts up and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((nstate != state) || rep_due || (state == IDLE)) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Registered outputs; hold and busy follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      hold         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_pulse  <= ev_short;
      long_pulse   <= ev_long;
      double_pulse <= ev_double;
      repeat_pulse <= ev_repeat;
      hold         <= (nstate == LONG);
      busy         <= (nstate != IDLE);
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Purpose: multi-channel push-button gesture classifier; one independent press_channel per button.
// Latency: one cycle from the deciding btn sample to each registered event/level output.
// Backpressure: none; pulses are single-cycle. Auto-repeat present only with PRESS_CLASSIFIER_REPEAT_EN.
module press_classifier
  import press_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] short_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] double_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] busy
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    press_channel #(
      .LONG_CYCLES  (LONG_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn[g]),
      .short_pulse (short_pulse[g]),
      .long_pulse  (long_pulse[g]),
      .double_pulse(double_pulse[g]),
      .repeat_pulse(repeat_pulse[g]),
      .hold        (hold[g]),
      .busy        (busy[g])
    );
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG=8, GAP=4, REPEAT=3, two channels.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
// Repeat expectations follow PRESS_CLASSIFIER_REPEAT_EN.
module tb_press_classifier;

  localparam int CH = 2;

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn;
  logic [CH-1:0] short_pulse, long_pulse, double_pulse, repeat_pulse, hold, busy;

  int errors = 0;
  int checks = 0;

  press_classifier #(
    .CHANNELS     (CH),
    .LONG_CYCLES  (8),
    .GAP_CYCLES   (4),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse),
    .hold        (hold),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Drive one btn sample, let it be clocked in, then compare every output.
  task automatic step(input string tag, input logic [1:0] b,
                      input logic [1:0] es, input logic [1:0] el, input logic [1:0] ed,
                      input logic [1:0] er, input logic [1:0] eh, input logic [1:0] eb);
    logic [11:0] got;
    logic [11:0] exp;
    btn = b;
    @(posedge clk);
    @(negedge clk);
    got = {short_pulse, long_pulse, double_pulse, repeat_pulse, hold, busy};
    exp = {es, el, ed, er, eh, eb};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed s/l/d/r/h/b=%b required=%b", tag, $time, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;

    // Reset state.
    step("reset0", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step("reset1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    step("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Short press: 3 high, then lows; short after the 4th low (sample 7).
    for (int i = 1; i <= 8; i++)
      step("short", {1'b0, i <= 3}, {1'b0, i == 7}, 2'b00, 2'b00, 2'b00, 2'b00, {1'b0, i <= 6});

    // One high short of a long press: still a short press (7 high, short at sample 11).
    for (int i = 1; i <= 12; i++)
      step("near_long", {1'b0, i <= 7}, {1'b0, i == 11}, 2'b00, 2'b00, 2'b00, 2'b00, {1'b0, i <= 10});

    // Long press: 12 high then release; long at 8, hold 8..12, repeat at 11 when enabled.
    for (int i = 1; i <= 13; i++)
      step("long", {1'b0, i <= 12}, 2'b00, {1'b0, i == 8}, 2'b00,
           {1'b0, REP_EN && (i == 11)}, {1'b0, (i >= 8) && (i <= 12)}, {1'b0, i <= 12});

    // Double click: H H L L H H L; double on the second release.
    for (int i = 1; i <= 8; i++)
      step("double", {1'b0, (i <= 2) || (i == 5) || (i == 6)}, 2'b00, 2'b00,
           {1'b0, i == 7}, 2'b00, 2'b00, {1'b0, i <= 6});

    // Second press on the last low before the gap closes: still a double click.
    for (int i = 1; i <= 7; i++)
      step("double_gap", {1'b0, (i == 1) || (i == 5)}, 2'b00, 2'b00,
           {1'b0, i == 6}, 2'b00, 2'b00, {1'b0, i <= 5});

    // Auto-repeat: 17 high; repeats at 11, 14, 17 when enabled, none otherwise.
    for (int i = 1; i <= 18; i++)
      step("repeat", {1'b0, i <= 17}, 2'b00, {1'b0, i == 8}, 2'b00,
           {1'b0, REP_EN && (i == 11 || i == 14 || i == 17)},
           {1'b0, (i >= 8) && (i <= 17)}, {1'b0, i <= 17});

    // Reset in WAIT_SECOND: pending short is dropped.
    step("mid_h1", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    step("mid_h2", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    step("mid_l1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    step("mid_l2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    reset = 1'b1;
    step("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++)
      step("mid_quiet", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Fresh press after reset: one high, short after the 4th low (sample 5).
    for (int i = 1; i <= 6; i++)
      step("post_reset", {1'b0, i == 1}, {1'b0, i == 5}, 2'b00, 2'b00, 2'b00, 2'b00, {1'b0, i <= 4});

    // Independence: ch0 short (3 high) alongside ch1 long (10 high). ch1 releases on
    // sample 11, exactly when a repeat would be due, so no repeat is expected.
    for (int i = 1; i <= 12; i++)
      step("indep", {i <= 10, i <= 3}, {1'b0, i == 7}, {i == 8, 1'b0}, 2'b00, 2'b00,
           {(i >= 8) && (i <= 10), 1'b0}, {i <= 10, i <= 6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
